spi_resp_rx: RTL and testbench
==============================

# spi_resp_rx

SPI response receiver in the `sclk` domain. It deserialises MISO bits into either one standard response word (STD_W bits) or a daisy-chain response of N_DEV 48-bit device words. On a complete frame it loads the parallel outputs, checks per-device parity and pulses `resp_done`. This block feeds `std_rx`, `aw_chain_rx` and `resp_done` directly into the response CDC stage, which captures them in the `resp_done` cycle.

## Interface
Parameters:
- STD_W, 60, standard response length in bits
- N_DEV, 4, devices in the chain; chain frame length is N_DEV*48 bits
- TO_CYC, 1024, timeout in `sclk` cycles between sampled bits while receiving; 0 disables the timeout

Ports:
- sclk  in  1  receive clock
- s_rst_n  in  1  reset s_rst_n, asynchronous, active-low; clock sclk
- rx_start  in  1  one-cycle pulse that begins a frame
- rx_mode  in  1  sampled with rx_start: 0 = standard frame, 1 = chain frame
- rx_en  in  1  bit-valid qualifier; miso is sampled when high
- miso  in  1  serial data, MSB first
- cs_active  in  1  chip select asserted; a low level mid-frame aborts the frame
- std_rx  out  STD_W  last completed standard frame
- aw_chain_rx  out  N_DEV*48  last completed chain frame; device i occupies [i*48 +: 48]
- par_err  out  N_DEV  per-device parity failure of the last completed frame
- resp_done  out  1  one-cycle pulse; outputs are valid in that cycle
- rx_err  out  1  one-cycle pulse on abort or timeout
- rx_busy  out  1  high while in SHIFT

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE or DONE, with rx_start high:
  - latch rx_mode;
  - set frame length L = STD_W (mode 0) or N_DEV*48 (mode 1);
  - clear the bit counter and timeout counter;
  - go to SHIFT.
- rx_start is ignored while in SHIFT.
- SHIFT, with rx_en high: shift miso into the internal shift register (LSB in, MSB first) and increment the bit counter. rx_en in the rx_start cycle is not sampled.
- Bit counter width is clog2(max(STD_W, N_DEV*48)+1).
- Final bit sampled (count reaches L):
  - mode 0: load std_rx from {shift, miso}[STD_W-1:0]; aw_chain_rx is unchanged; par_err is cleared to 0.
  - mode 1: load aw_chain_rx from {shift, miso}. The first bit received lands in aw_chain_rx[N_DEV*48-1], so device N_DEV-1 arrives first. std_rx is unchanged.
  - mode 1 parity: par_err[i] = ~^word_i, where word_i = aw_chain_rx[i*48 +: 48]. Each word needs odd parity over all 48 bits.
  - go to DONE.
- DONE: resp_done = 1 for exactly one cycle, then go to IDLE. rx_start in DONE is accepted, so back-to-back frames are allowed.
- Abort: in SHIFT with cs_active low and the final bit not sampled in that cycle, go to IDLE and pulse rx_err. Outputs and par_err are unchanged and resp_done is not asserted.
- Timeout: the counter increments every SHIFT cycle without a sampled bit and clears on each sampled bit. Reaching TO_CYC (when nonzero) gives the same action as an abort.
- Partial or aborted frames never disturb the output registers.

## Timing
- Reset: state IDLE; std_rx, aw_chain_rx, par_err, resp_done, rx_err, rx_busy, internal shift register and counters all 0.
- rx_start at cycle t: rx_busy = 1 from t+1. The first bit can be sampled at t+1.
- Final bit sampled at cycle c: outputs, par_err and resp_done all update on the edge ending c and are visible in c+1. rx_busy = 0 in c+1.
- Minimum frame latency with rx_en held high: resp_done at t+L+1.
- Abort or timeout detected in cycle c: rx_err = 1 and rx_busy = 0 in c+1.
- Simultaneous final bit and cs_active low: the frame completes and no rx_err is raised.
- Simultaneous final bit and timeout expiry: the sampled bit clears the timeout, so the frame completes.
- Asynchronous reset mid-frame: immediate return to reset values. No resp_done or rx_err is issued.
- resp_done and rx_err are never high in the same cycle.

## Test plan
- Standard frame: mode 0, 60 bits of 0xABCDEF012345678 with rx_en always high → std_rx = 0xABCDEF012345678, resp_done high for one cycle at t+61, par_err = 0, aw_chain_rx unchanged.
- Chain frame: N_DEV=4, words (dev3..dev0 sent in that order) 0x800000000000, 0x000000000001, 0x123456789AB0, 0xFFFFFFFFFFFE → aw_chain_rx matches, par_err = 4'b0010 (dev1 has even parity), resp_done pulses.
- Gapped bits: the same standard frame with rx_en low on random cycles (gaps < TO_CYC) → identical std_rx. An rx_start pulse mid-frame is ignored.
- Abort: cs_active low after 30 sampled bits → rx_err one cycle, no resp_done, std_rx keeps its prior value.
- Timeout: TO_CYC=16, rx_en low for 16 cycles after 10 bits → rx_err one cycle, rx_busy = 0, outputs unchanged. A following full frame completes normally.
- Reset mid-frame: assert s_rst_n low after 20 bits → all outputs 0, no pulses. After release, a complete chain frame produces correct data.

Source files
------------

// File: rtl/spi_resp_rx.sv
// SPI response receiver: deserialises MISO into a standard word or a daisy chain
// of 48-bit device words, checks per-device odd parity and flags abort/timeout.
module spi_resp_rx #(
  parameter int STD_W  = 60,
  parameter int N_DEV  = 4,
  parameter int TO_CYC = 1024
) (
  input  logic                  sclk,
  input  logic                  s_rst_n,
  input  logic                  rx_start,
  input  logic                  rx_mode,
  input  logic                  rx_en,
  input  logic                  miso,
  input  logic                  cs_active,
  output logic [STD_W-1:0]      std_rx,
  output logic [N_DEV*48-1:0]   aw_chain_rx,
  output logic [N_DEV-1:0]      par_err,
  output logic                  resp_done,
  output logic                  rx_err,
  output logic                  rx_busy
);

  localparam int CHAIN_W = N_DEV * 48;
  localparam int MAX_W   = (STD_W > CHAIN_W) ? STD_W : CHAIN_W;
  localparam int SH_W    = MAX_W - 1;
  localparam int CW      = $clog2(MAX_W + 1);
  localparam int TW      = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

  localparam logic [CW-1:0] STD_LEN   = CW'(STD_W);
  localparam logic [CW-1:0] CHAIN_LEN = CW'(CHAIN_W);
  localparam logic [TW-1:0] TO_LIM    = TW'(TO_CYC);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_mode;
  logic [SH_W-1:0]      r_shift;
  logic [CW-1:0]        r_cnt;
  logic [TW-1:0]        r_to;
  logic [STD_W-1:0]     r_std;
  logic [CHAIN_W-1:0]   r_chain;
  logic [N_DEV-1:0]     r_par;
  logic                 r_err;

  logic                 w_start;
  logic                 w_final;
  logic                 w_fail;
  logic                 w_to_hit;
  logic [CW-1:0]        w_len;
  logic [CW-1:0]        w_cnt_inc;
  logic [TW-1:0]        w_to_inc;
  logic [STD_W-1:0]     w_std_word;
  logic [CHAIN_W-1:0]   w_chain_word;
  logic [N_DEV-1:0]     w_par;

  assign w_len        = r_mode ? CHAIN_LEN : STD_LEN;
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_to_inc     = r_to + 1'b1;
  assign w_to_hit     = (TO_CYC != 0) && !rx_en && (w_to_inc == TO_LIM);
  // Candidate frames include the bit sampled this cycle, so completion needs no extra cycle.
  assign w_std_word   = {r_shift[STD_W-2:0], miso};
  assign w_chain_word = {r_shift[CHAIN_W-2:0], miso};

  generate
    for (genvar gi = 0; gi < N_DEV; gi++) begin : g_par
      assign w_par[gi] = ~^w_chain_word[gi*48 +: 48];
    end
  endgenerate

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_final      = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_state_next = IDLE;
        if (rx_start) begin
          w_start      = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        // A final sample wins over a simultaneous abort or timeout.
        if (rx_en && (w_cnt_inc == w_len)) begin
          w_final      = 1'b1;
          w_state_next = DONE;
        end else if (!cs_active || w_to_hit) begin
          w_fail       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_mode  <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_to    <= '0;
      r_std   <= '0;
      r_chain <= '0;
      r_par   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_fail;
      if (w_start) begin
        r_mode  <= rx_mode;
        r_shift <= '0;
        r_cnt   <= '0;
        r_to    <= '0;
      end else if (r_state == SHIFT) begin
        if (rx_en) begin
          r_shift <= {r_shift[SH_W-2:0], miso};
          r_cnt   <= w_cnt_inc;
          r_to    <= '0;
        end else begin
          r_to    <= w_to_inc;
        end
      end
      if (w_final) begin
        if (r_mode) begin
          r_chain <= w_chain_word;
          r_par   <= w_par;
        end else begin
          r_std   <= w_std_word;
          r_par   <= '0;
        end
      end
    end
  end

  assign std_rx      = r_std;
  assign aw_chain_rx = r_chain;
  assign par_err     = r_par;
  assign resp_done   = (r_state == DONE);
  assign rx_err      = r_err;
  assign rx_busy     = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_resp_rx.sv
// Directed bench for spi_resp_rx: standard/chain frames, gaps, abort, timeout,
// back-to-back frames and asynchronous reset mid-frame.
module tb_spi_resp_rx;

  localparam int STD_W  = 60;
  localparam int N_DEV  = 4;
  localparam int TO_CYC = 16;
  localparam int CH_W   = N_DEV * 48;

  localparam logic [59:0]   STD_A = 60'hABCDEF012345678;
  localparam logic [59:0]   STD_B = 60'h0F1E2D3C4B5A697;
  localparam logic [191:0]  CHAIN = {48'h800000000000, 48'h000000000001,
                                     48'h123456789AB0, 48'hFFFFFFFFFFFE};

  logic              sclk;
  logic              s_rst_n;
  logic              rx_start;
  logic              rx_mode;
  logic              rx_en;
  logic              miso;
  logic              cs_active;
  logic [STD_W-1:0]  std_rx;
  logic [CH_W-1:0]   aw_chain_rx;
  logic [N_DEV-1:0]  par_err;
  logic              resp_done;
  logic              rx_err;
  logic              rx_busy;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  int err_seen  = 0;

  spi_resp_rx #(.STD_W(STD_W), .N_DEV(N_DEV), .TO_CYC(TO_CYC)) dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .rx_start    (rx_start),
    .rx_mode     (rx_mode),
    .rx_en       (rx_en),
    .miso        (miso),
    .cs_active   (cs_active),
    .std_rx      (std_rx),
    .aw_chain_rx (aw_chain_rx),
    .par_err     (par_err),
    .resp_done   (resp_done),
    .rx_err      (rx_err),
    .rx_busy     (rx_busy)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  always @(posedge sclk) begin
    if (resp_done) done_seen <= done_seen + 1;
    if (rx_err)    err_seen  <= err_seen + 1;
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic start_frame(input logic mode);
    rx_mode  = mode;
    rx_start = 1'b1;
    rx_en    = 1'b0;
    tick();
    rx_start = 1'b0;
  endtask

  // Sends d[n-1:0] MSB first; optional 2-cycle gaps with one stray rx_start,
  // optional cs_active drop on the final bit.
  task automatic send_bits(input logic [191:0] d, input int n, input bit gapped, input bit last_cs_low);
    for (int i = 0; i < n; i++) begin
      if (gapped && (i % 7 == 3)) begin
        rx_en = 1'b0;
        for (int g = 0; g < 2; g++) begin
          if (i == 24 && g == 0) begin
            rx_start = 1'b1;
            rx_mode  = 1'b1;
          end
          tick();
          rx_start = 1'b0;
        end
      end
      rx_en = 1'b1;
      miso  = d[n-1-i];
      if (last_cs_low && i == n - 1) cs_active = 1'b0;
      tick();
    end
    rx_en     = 1'b0;
    cs_active = 1'b1;
  endtask

  initial begin
    s_rst_n   = 1'b0;
    rx_start  = 1'b0;
    rx_mode   = 1'b0;
    rx_en     = 1'b0;
    miso      = 1'b0;
    cs_active = 1'b1;
    repeat (3) tick();
    check("rst_std",   192'(std_rx),      192'd0);
    check("rst_chain", aw_chain_rx,       192'd0);
    check("rst_par",   192'(par_err),     192'd0);
    check("rst_done",  192'(resp_done),   192'd0);
    check("rst_err",   192'(rx_err),      192'd0);
    check("rst_busy",  192'(rx_busy),     192'd0);
    s_rst_n = 1'b1;
    tick();

    // Chain frame
    start_frame(1'b1);
    check("chain_busy", 192'(rx_busy), 192'd1);
    send_bits(CHAIN, CH_W, 1'b0, 1'b0);
    check("chain_done",  192'(resp_done), 192'd1);
    check("chain_data",  aw_chain_rx,     CHAIN);
    check("chain_par",   192'(par_err),   192'b0010);
    check("chain_std",   192'(std_rx),    192'd0);
    check("chain_nbusy", 192'(rx_busy),   192'd0);
    tick();
    check("chain_pulse", 192'(resp_done), 192'd0);
    check("chain_cnt",   192'(done_seen), 192'd1);

    // Standard frame, resp_done at t+61
    start_frame(1'b0);
    send_bits(192'(STD_A), STD_W, 1'b0, 1'b0);
    check("std_done",  192'(resp_done), 192'd1);
    check("std_data",  192'(std_rx),    192'(STD_A));
    check("std_par",   192'(par_err),   192'd0);
    check("std_chain", aw_chain_rx,     CHAIN);
    tick();
    check("std_cnt",   192'(done_seen), 192'd2);

    // Abort after 30 bits
    start_frame(1'b0);
    send_bits(192'(STD_B), 30, 1'b0, 1'b0);
    cs_active = 1'b0;
    tick();
    check("abort_err",  192'(rx_err),    192'd1);
    check("abort_busy", 192'(rx_busy),   192'd0);
    check("abort_done", 192'(resp_done), 192'd0);
    cs_active = 1'b1;
    tick();
    check("abort_pulse", 192'(rx_err),    192'd0);
    check("abort_std",   192'(std_rx),    192'(STD_A));
    check("abort_errs",  192'(err_seen),  192'd1);
    check("abort_dones", 192'(done_seen), 192'd2);

    // Timeout: 16 idle cycles after 10 bits
    start_frame(1'b0);
    send_bits(192'(STD_B), 10, 1'b0, 1'b0);
    repeat (15) tick();
    check("to_early_err",  192'(rx_err),  192'd0);
    check("to_early_busy", 192'(rx_busy), 192'd1);
    tick();
    check("to_err",  192'(rx_err),  192'd1);
    check("to_busy", 192'(rx_busy), 192'd0);
    tick();
    check("to_errs",  192'(err_seen),   192'd2);
    check("to_std",   192'(std_rx),     192'(STD_A));
    check("to_chain", aw_chain_rx,      CHAIN);

    // Final bit with cs_active low completes; then back-to-back gapped frame
    start_frame(1'b0);
    send_bits(192'(STD_B), STD_W, 1'b0, 1'b1);
    check("cslast_done", 192'(resp_done), 192'd1);
    check("cslast_std",  192'(std_rx),    192'(STD_B));
    check("cslast_err",  192'(rx_err),    192'd0);
    start_frame(1'b0);
    check("b2b_busy", 192'(rx_busy), 192'd1);
    send_bits(192'(STD_A), STD_W, 1'b1, 1'b0);
    check("gap_done", 192'(resp_done), 192'd1);
    check("gap_std",  192'(std_rx),    192'(STD_A));
    tick();
    check("gap_errs",  192'(err_seen),  192'd2);
    check("gap_dones", 192'(done_seen), 192'd4);

    // Asynchronous reset mid-frame
    start_frame(1'b1);
    send_bits(CHAIN, 20, 1'b0, 1'b0);
    #2 s_rst_n = 1'b0;
    #1;
    check("mrst_std",   192'(std_rx),    192'd0);
    check("mrst_chain", aw_chain_rx,     192'd0);
    check("mrst_par",   192'(par_err),   192'd0);
    check("mrst_busy",  192'(rx_busy),   192'd0);
    check("mrst_done",  192'(resp_done), 192'd0);
    check("mrst_err",   192'(rx_err),    192'd0);
    tick();
    s_rst_n = 1'b1;
    tick();
    check("mrst_dones", 192'(done_seen), 192'd4);
    check("mrst_errs",  192'(err_seen),  192'd2);
    start_frame(1'b1);
    send_bits(CHAIN, CH_W, 1'b0, 1'b0);
    check("post_done",  192'(resp_done), 192'd1);
    check("post_chain", aw_chain_rx,     CHAIN);
    check("post_par",   192'(par_err),   192'b0010);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
